// File: rtl/lap_recorder_pkg.sv
// Shared types and BCD helpers for the lap recorder stopwatch.
package lap_recorder_pkg;

    localparam int DIGITS  = 8;
    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [DIGITS-1:0] record_t;

    // Increment a two-digit BCD pair that wraps to 00 after max_val.
    // Result is {wrapped, hi, lo}; wrapped is the carry into the next pair.
    function automatic logic [8:0] pair_inc(input bcd_t hi, input bcd_t lo, input int max_val);
        bcd_t       max_hi;
        bcd_t       max_lo;
        logic [8:0] r;
        max_hi = bcd_t'(max_val / 10);
        max_lo = bcd_t'(max_val % 10);
        if (hi == max_hi && lo == max_lo) begin
            r = {1'b1, 8'h00};
        end else if (lo == 4'd9) begin
            r = {1'b0, hi + 4'd1, 4'd0};
        end else begin
            r = {1'b0, hi, lo + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/lap_recorder_key_debounce.sv
// Lap key synchroniser, debouncer and press detector.
// LAP_RECORDER_DEBOUNCE_EN selects the counting debouncer; otherwise the synchronised key is used directly.
module key_debounce #(
    parameter int DEB_CYCLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic press
);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end

    logic [1:0] key_sync;
    logic [1:0] valid_sync;
    logic       key_s;
    logic       stable;
    logic       armed;
    logic       fall;

    assign key_s = key_sync[1];

    // A press only counts once a genuine released level has been seen after
    // reset, so a key held through reset never produces an insert.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_sync   <= 2'b11;
            valid_sync <= 2'b00;
            armed      <= 1'b0;
        end else begin
            key_sync   <= {key_sync[0], key};
            valid_sync <= {valid_sync[0], 1'b1};
            if (valid_sync[1] && key_s) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef LAP_RECORDER_DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (key_s != stable) && (cnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (key_s == stable) begin
            cnt <= '0;
        end else if (flip) begin
            stable <= ~stable;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign fall = flip & stable;
`else
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable <= 1'b1;
        end else begin
            stable <= key_s;
        end
    end

    assign fall = stable & ~key_s;
`endif

    assign press = fall & armed;

endmodule

// File: rtl/lap_recorder.sv
// BCD stopwatch HH:MM:SS.CC with debounced lap capture feeding the LCD record bridge.
// Lap debounce is enabled by defining LAP_RECORDER_DEBOUNCE_EN.
module lap_recorder
    import lap_recorder_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        clear,
    input  logic        lap_key,
    output logic        insert,
    output logic [31:0] new_record,
    output logic [31:0] live_time,
    output logic        running
);

    localparam int PRESCALE   = CLK_HZ / TICK_HZ;
    localparam int DEB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    if (CLK_HZ % TICK_HZ != 0) begin : g_bad_rate
        $error("CLK_HZ must be an integer multiple of TICK_HZ");
    end

    logic [1:0]    run_sync;
    logic [1:0]    clear_sync;
    logic          run_s;
    logic          clear_s;
    logic          tick;
    logic          press;
    logic [PW-1:0] pre_cnt;
    record_t       time_q;
    record_t       time_nxt;
    logic [8:0]    cs_inc;
    logic [8:0]    sec_inc;
    logic [8:0]    min_inc;
    logic [8:0]    hr_inc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_sync   <= 2'b00;
            clear_sync <= 2'b00;
        end else begin
            run_sync   <= {run_sync[0], run};
            clear_sync <= {clear_sync[0], clear};
        end
    end

    assign run_s   = run_sync[1];
    assign clear_s = clear_sync[1];
    assign running = run_s & ~clear_s;
    assign tick    = running && (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (clear_s || tick) begin
            pre_cnt <= '0;
        end else if (running) begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign cs_inc  = pair_inc(time_q[1], time_q[0], CS_MAX);
    assign sec_inc = pair_inc(time_q[3], time_q[2], SEC_MAX);
    assign min_inc = pair_inc(time_q[5], time_q[4], MIN_MAX);
    assign hr_inc  = pair_inc(time_q[7], time_q[6], HR_MAX);

    // Each pair advances only when every lower pair wraps on this tick.
    always_comb begin
        time_nxt      = time_q;
        time_nxt[1:0] = cs_inc[7:0];
        if (cs_inc[8]) begin
            time_nxt[3:2] = sec_inc[7:0];
            if (sec_inc[8]) begin
                time_nxt[5:4] = min_inc[7:0];
                if (min_inc[8]) begin
                    time_nxt[7:6] = hr_inc[7:0];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            time_q <= '0;
        end else if (clear_s) begin
            time_q <= '0;
        end else if (tick) begin
            time_q <= time_nxt;
        end
    end

    // Capture samples time_q before this edge's tick or clear lands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            insert     <= 1'b0;
            new_record <= '0;
        end else begin
            insert <= press;
            if (press) begin
                new_record <= time_q;
            end
        end
    end

    assign live_time = time_q;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_lap_key (
        .clock(clock),
        .reset(reset),
        .key  (lap_key),
        .press(press)
    );

endmodule

// File: doc/lap_recorder.md
# lap_recorder

Upstream feeder for the LCD record bridge. Runs an 8-digit BCD stopwatch (HH:MM:SS.CC) and debounces a lap key. On each debounced press it snapshots the running time onto `new_record` and issues a one-cycle `insert` pulse. Sits between the board keys/switches and `lcd_bridge`, replacing the constant record and raw switch used for bring-up.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency in Hz
- `TICK_HZ`, 100, stopwatch count rate (centiseconds); `CLK_HZ` must be an integer multiple
- `DEBOUNCE_MS`, 20, lap-key stable time in ms
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `run`  in  1  level; 1 = count, 0 = hold (asynchronous switch, synchronised internally)
- `clear`  in  1  level; 1 = force time to zero (synchronised internally)
- `lap_key`  in  1  raw push-button, active-low (0 = pressed)
- `insert`  out  1  one-cycle pulse; `new_record` is valid in the same cycle and stays stable until the next pulse
- `new_record`  out  32  captured time {H1,H0,M1,M0,S1,S0,C1,C0}, 4-bit BCD each, H1 in [31:28]
- `live_time`  out  32  current time, same format
- `running`  out  1  synchronised `run` and not `clear`

## Operation
- Derived constants: `PRESCALE = CLK_HZ/TICK_HZ`; `DEB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS`.
- Inputs `run`, `clear`, `lap_key` each pass through a 2-FF synchroniser; synchroniser flops reset to idle (`run`=0, `clear`=0, `lap_key`=1).
- Prescaler counts 0..`PRESCALE`-1 while `running`. `tick` asserts on the cycle it equals `PRESCALE`-1, then it wraps to 0. The prescaler holds when not running and zeroes on clear.
- BCD chain on `tick`: C 00..99 → S 00..59 → M 00..59 → H 00..23. Each digit pair carries only when all lower pairs wrap. 23:59:59.99 + tick → 00:00:00.00. Digits never hold non-BCD values.
- Clear has priority over tick: digits and prescaler are 0 in the cycle after synchronised `clear` is seen.
- Lap debounce: a `stable` level starts at 1. A counter increments while the synchronised key ≠ `stable`, and resets to 0 when they are equal. When the counter reaches `DEB_CYCLES`-1 with mismatch, `stable` toggles and the counter resets.
- Press event = `stable` 1→0. On that edge `new_record` loads `live_time` as it is before any same-cycle tick or clear, and `insert` = 1 for that one cycle. Release (0→1) produces no event.
- Capture works whether or not running. A new press requires a full debounced release first, so the minimum `insert` spacing is 2·`DEB_CYCLES` cycles.

## Timing
- Reset values: `insert`=0, `new_record`=0, `live_time`=0, `running`=0, prescaler=0, `stable`=1, debounce counter=0.
- `insert` and `new_record` are registered. With `lap_key` held low from edge k, `insert` is high in the cycle after edge k+1+`DEB_CYCLES` (2 synchroniser edges + `DEB_CYCLES`).
- Bounce shorter than `DEB_CYCLES` cycles produces no event.
- `live_time` updates on the edge after `tick`. It lags `run`/`clear` changes by 3 edges (2 sync + 1 register).
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). A pending debounce is discarded, and no `insert` is issued on release of reset even if the key is held.

## Configuration
- `LAP_RECORDER_DEBOUNCE_EN` defined: debounce as above.
- Not defined: `stable` follows the synchronised key directly (counter removed). `insert` fires on the cycle after the synchronised falling edge, i.e. 3 edges after the key is sampled low. This mode is for simulation and the debug switch only.

## Structure
- Package `lap_recorder_pkg`:
  - `bcd_t` (4-bit)
  - `record_t` (8×`bcd_t`, packed 32 bits)
  - digit-limit constants (`CS_MAX`=99, `SEC_MAX`=59, `MIN_MAX`=59, `HR_MAX`=23)
  - `DIGITS`=8
- Sub-module `key_debounce`: synchroniser + stable/counter + falling-edge pulse, parameterised by `DEB_CYCLES`. It contains the `LAP_RECORDER_DEBOUNCE_EN` switch. `lap_recorder` instantiates it once.

## Test plan
Bench uses `CLK_HZ`=1000, `TICK_HZ`=100 (`PRESCALE`=10), `DEBOUNCE_MS`=3 (`DEB_CYCLES`=3), macro defined.
- Reset low 5 cycles, then high, `run`=0 → all outputs 0 and `insert` never asserts over 100 cycles.
- `run`=1 for 1000 cycles → `live_time` = 0x00000100 (01.00 s); prescaler resumes without drift after `run` toggles 0→1.
- Preload the counter to 23:59:59.99 (by running), then one tick → `live_time` = 0x00000000 with no non-BCD nibble at any intermediate cycle.
- `lap_key` low with 2-cycle bounces, then held low → exactly one `insert`, at edge k+1+3 after the final low. `new_record` equals the pre-edge `live_time`, and no second pulse until released ≥3 cycles.
- Press event in the same cycle as `tick` and as `clear` → `new_record` holds the pre-increment/pre-clear value; `live_time` is 0 after clear.
- Assert `reset` during debounce count → no `insert` after release of reset while the key is held; the next release + press yields one pulse.
